// File: rtl/craps_controller.sv
// craps_controller: game-control FSM for the craps dice datapath (roll requests, rules, status).
// Define CRAPS_STATS_EN to add saturating win/lose counters that persist across games.
module craps_controller #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_roll_btn,
  input  logic [3:0]       i_sum,
  input  logic             i_sum_valid,
  output logic             o_roll_req,
  output logic             o_sp,
  output logic [3:0]       o_point,
  output logic             o_phase,
  output logic             o_busy,
  output logic             o_win,
  output logic             o_lose,
  output logic             o_err,
`ifdef CRAPS_STATS_EN
  output logic [CNT_W-1:0] o_win_count,
  output logic [CNT_W-1:0] o_lose_count,
`endif
  output logic [CNT_W-1:0] o_roll_count
);

  localparam int unsigned      WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StComeIdle,
    StComeWait,
    StPtIdle,
    StPtWait,
    StWin,
    StLose
  } state_e;

  state_e           r_state;
  logic             r_btn_q;
  logic [WaitW-1:0] r_wait_cnt;

  logic             w_press;
  logic             w_sum_legal;
  logic             w_natural;
  logic             w_craps;
  logic             w_win_entry;
  logic             w_lose_entry;
  logic [CNT_W-1:0] w_roll_inc;

  assign w_press     = i_roll_btn & ~r_btn_q;
  assign w_sum_legal = (i_sum >= 4'd2) && (i_sum <= 4'd12);
  assign w_natural   = (i_sum == 4'd7) || (i_sum == 4'd11);
  assign w_craps     = (i_sum == 4'd2) || (i_sum == 4'd3) || (i_sum == 4'd12);
  assign w_roll_inc  = (&o_roll_count) ? o_roll_count : o_roll_count + 1'b1;

  // Game-ending decisions; the point can never be 7, so win and lose are exclusive.
  assign w_win_entry  = i_sum_valid && w_sum_legal &&
                        (((r_state == StComeWait) && w_natural) ||
                         ((r_state == StPtWait) && (i_sum == o_point)));
  assign w_lose_entry = i_sum_valid && w_sum_legal &&
                        (((r_state == StComeWait) && w_craps) ||
                         ((r_state == StPtWait) && (i_sum == 4'd7)));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StComeIdle;
      r_btn_q      <= 1'b0;
      r_wait_cnt   <= '0;
      o_roll_req   <= 1'b0;
      o_sp         <= 1'b0;
      o_point      <= 4'd0;
      o_phase      <= 1'b0;
      o_busy       <= 1'b0;
      o_win        <= 1'b0;
      o_lose       <= 1'b0;
      o_err        <= 1'b0;
      o_roll_count <= '0;
    end else begin
      r_btn_q    <= i_roll_btn;
      o_roll_req <= 1'b0;
      o_sp       <= 1'b0;
      unique case (r_state)
        StComeIdle: begin
          if (w_press) begin
            o_roll_req   <= 1'b1;
            o_busy       <= 1'b1;
            o_err        <= 1'b0;
            o_roll_count <= w_roll_inc;
            r_wait_cnt   <= '0;
            r_state      <= StComeWait;
          end
        end
        StPtIdle: begin
          if (w_press) begin
            o_roll_req   <= 1'b1;
            o_busy       <= 1'b1;
            o_err        <= 1'b0;
            o_roll_count <= w_roll_inc;
            r_wait_cnt   <= '0;
            r_state      <= StPtWait;
          end
        end
        StWin, StLose: begin
          if (w_press) begin
            o_win        <= 1'b0;
            o_lose       <= 1'b0;
            o_point      <= 4'd0;
            o_phase      <= 1'b0;
            o_err        <= 1'b0;
            o_roll_count <= CNT_W'(1);
            o_roll_req   <= 1'b1;
            o_busy       <= 1'b1;
            r_wait_cnt   <= '0;
            r_state      <= StComeWait;
          end
        end
        StComeWait, StPtWait: begin
          if (i_sum_valid) begin
            o_busy <= 1'b0;
            if (!w_sum_legal) begin
              o_err   <= 1'b1;
              r_state <= (r_state == StComeWait) ? StComeIdle : StPtIdle;
            end else if (w_win_entry) begin
              o_win   <= 1'b1;
              r_state <= StWin;
            end else if (w_lose_entry) begin
              o_lose  <= 1'b1;
              r_state <= StLose;
            end else if (r_state == StComeWait) begin
              o_point <= i_sum;
              o_sp    <= 1'b1;
              o_phase <= 1'b1;
              r_state <= StPtIdle;
            end else begin
              r_state <= StPtIdle;
            end
          end else if (r_wait_cnt == WaitLast) begin
            o_busy  <= 1'b0;
            o_err   <= 1'b1;
            r_state <= (r_state == StComeWait) ? StComeIdle : StPtIdle;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= StComeIdle;
      endcase
    end
  end

`ifdef CRAPS_STATS_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_win_count  <= '0;
      o_lose_count <= '0;
    end else begin
      if (w_win_entry && !(&o_win_count)) begin
        o_win_count <= o_win_count + 1'b1;
      end
      if (w_lose_entry && !(&o_lose_count)) begin
        o_lose_count <= o_lose_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_craps_controller.sv
// Self-checking bench for craps_controller: directed vector table, corner sequences and a
// randomized run against a rules-level game model. Stats counters checked when CRAPS_STATS_EN.
module tb_craps_controller;

  localparam int unsigned TO    = 64;
  localparam int unsigned CW    = 8;
  localparam int          RCMAX = (1 << CW) - 1;

  typedef logic [18:0] outv_t;

  typedef struct {
    logic       btn;
    logic       sv;
    logic [3:0] sum;
    outv_t      exp;
  } vec_t;

  logic          i_clock;
  logic          i_reset;
  logic          i_roll_btn;
  logic [3:0]    i_sum;
  logic          i_sum_valid;
  logic          o_roll_req;
  logic          o_sp;
  logic [3:0]    o_point;
  logic          o_phase;
  logic          o_busy;
  logic          o_win;
  logic          o_lose;
  logic          o_err;
  logic [CW-1:0] o_roll_count;
`ifdef CRAPS_STATS_EN
  logic [CW-1:0] o_win_count;
  logic [CW-1:0] o_lose_count;
`endif

  craps_controller #(
    .TIMEOUT(TO),
    .CNT_W  (CW)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_roll_btn  (i_roll_btn),
    .i_sum       (i_sum),
    .i_sum_valid (i_sum_valid),
    .o_roll_req  (o_roll_req),
    .o_sp        (o_sp),
    .o_point     (o_point),
    .o_phase     (o_phase),
    .o_busy      (o_busy),
    .o_win       (o_win),
    .o_lose      (o_lose),
    .o_err       (o_err),
`ifdef CRAPS_STATS_EN
    .o_win_count (o_win_count),
    .o_lose_count(o_lose_count),
`endif
    .o_roll_count(o_roll_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t tbl[$];

  // Rules-level model of the game as seen by the player.
  logic m_btn_prev, m_busy, m_phase, m_win, m_lose, m_err, m_req, m_sp;
  int   m_wait, m_point, m_rolls, m_wins, m_losses;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic outv_t pk(input int req, input int sp, input int point, input int phase,
                               input int busy, input int win, input int lose, input int err,
                               input int rc);
    return {req[0], sp[0], point[3:0], phase[0], busy[0], win[0], lose[0], err[0], rc[7:0]};
  endfunction

  function automatic outv_t dut_out();
    return {o_roll_req, o_sp, o_point, o_phase, o_busy, o_win, o_lose, o_err, o_roll_count};
  endfunction

  task automatic add(input int btn, input int sv, input int sum, input outv_t exp);
    vec_t v;
    v.btn = (btn != 0);
    v.sv  = (sv != 0);
    v.sum = 4'(sum);
    v.exp = exp;
    tbl.push_back(v);
  endtask

  function automatic void model_reset();
    m_btn_prev = 0; m_busy = 0; m_phase = 0; m_win = 0; m_lose = 0; m_err = 0;
    m_req = 0; m_sp = 0; m_wait = 0; m_point = 0; m_rolls = 0; m_wins = 0; m_losses = 0;
  endfunction

  function automatic void model_edge(input logic btn, input logic sv, input int s);
    logic press;
    press      = btn && !m_btn_prev;
    m_btn_prev = btn;
    m_req      = 0;
    m_sp       = 0;
    if (m_busy) begin
      if (sv) begin
        m_busy = 0;
        if (s < 2 || s > 12) m_err = 1;
        else if (!m_phase) begin
          if (s == 7 || s == 11) begin m_win = 1; m_wins++; end
          else if (s == 2 || s == 3 || s == 12) begin m_lose = 1; m_losses++; end
          else begin m_point = s; m_phase = 1; m_sp = 1; end
        end else if (s == m_point) begin m_win = 1; m_wins++; end
        else if (s == 7) begin m_lose = 1; m_losses++; end
      end else begin
        m_wait++;
        if (m_wait == TO) begin m_busy = 0; m_err = 1; end
      end
    end else if (press) begin
      if (m_win || m_lose) begin
        m_win = 0; m_lose = 0; m_point = 0; m_phase = 0; m_rolls = 1;
      end else if (m_rolls < RCMAX) m_rolls++;
      m_err = 0; m_req = 1; m_busy = 1; m_wait = 0;
    end
    if (m_wins > RCMAX) m_wins = RCMAX;
    if (m_losses > RCMAX) m_losses = RCMAX;
  endfunction

  function automatic outv_t model_out();
    return pk(int'(m_req), int'(m_sp), m_point, int'(m_phase), int'(m_busy), int'(m_win),
              int'(m_lose), int'(m_err), m_rolls);
  endfunction

  task automatic do_reset();
    i_reset = 1; i_roll_btn = 0; i_sum_valid = 0; i_sum = 0;
    @(posedge i_clock);
    @(negedge i_clock);
    check("reset_state", 32'(dut_out()), 32'd0);
    i_reset = 0;
  endtask

  task automatic roll(input int s);
    i_roll_btn = 1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_roll_btn = 0; i_sum_valid = 1; i_sum = 4'(s);
    @(posedge i_clock);
    @(negedge i_clock);
    i_sum_valid = 0;
  endtask

  initial begin
    int busy_cycles;
    i_reset = 1; i_roll_btn = 0; i_sum_valid = 0; i_sum = 0;

    //   btn sv sum      req sp pt ph bsy win lose err rc
    add(1, 0, 0,  pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    add(0, 1, 6,  pk(0, 1, 6, 1, 0, 0, 0, 0, 1));
    add(1, 0, 0,  pk(1, 0, 6, 1, 1, 0, 0, 0, 2));
    add(0, 1, 8,  pk(0, 0, 6, 1, 0, 0, 0, 0, 2));
    add(1, 0, 0,  pk(1, 0, 6, 1, 1, 0, 0, 0, 3));
    add(0, 1, 6,  pk(0, 0, 6, 1, 0, 1, 0, 0, 3));
    add(1, 0, 0,  pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    add(0, 1, 7,  pk(0, 0, 0, 0, 0, 1, 0, 0, 1));
    add(1, 0, 0,  pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    add(0, 1, 13, pk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 1, 7,  pk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    add(1, 0, 0,  pk(1, 0, 0, 0, 1, 0, 0, 0, 2));
    add(1, 1, 3,  pk(0, 0, 0, 0, 0, 0, 1, 0, 2));
    add(0, 0, 0,  pk(0, 0, 0, 0, 0, 0, 1, 0, 2));
    add(1, 0, 0,  pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    add(0, 0, 0,  pk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    add(1, 0, 0,  pk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    add(0, 1, 2,  pk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    add(1, 0, 0,  pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    add(0, 1, 9,  pk(0, 1, 9, 1, 0, 0, 0, 0, 1));
    add(1, 0, 0,  pk(1, 0, 9, 1, 1, 0, 0, 0, 2));
    add(0, 1, 7,  pk(0, 0, 9, 1, 0, 0, 1, 0, 2));
    add(1, 0, 0,  pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    add(0, 1, 11, pk(0, 0, 0, 0, 0, 1, 0, 0, 1));

    do_reset();
    foreach (tbl[i]) begin
      i_roll_btn = tbl[i].btn; i_sum_valid = tbl[i].sv; i_sum = tbl[i].sum;
      @(posedge i_clock);
      @(negedge i_clock);
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Timeout: busy for exactly TO cycles, then err; next press clears err.
    do_reset();
    i_roll_btn = 1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_roll_btn = 0;
    busy_cycles = 0;
    while (o_busy === 1'b1 && busy_cycles < 4 * TO) begin
      busy_cycles++;
      @(negedge i_clock);
    end
    check("timeout_len", 32'(busy_cycles), 32'(TO));
    check("timeout_err", 32'(o_err), 32'd1);
    i_roll_btn = 1;
    @(posedge i_clock);
    @(negedge i_clock);
    check("press_clears_err", 32'({o_err, o_roll_req, o_busy}), 32'b011);
    i_roll_btn = 0;

    // Asynchronous reset during the point-phase wait, then a stale sum_valid.
    do_reset();
    roll(5);
    check("point5", 32'({o_point, o_phase}), 32'b01011);
    i_roll_btn = 1;
    @(posedge i_clock);
    @(negedge i_clock);
    check("pt_wait_busy", 32'(o_busy), 32'd1);
    i_reset = 1;
    #1;
    check("async_reset", 32'(dut_out()), 32'd0);
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 0; i_roll_btn = 0; i_sum_valid = 1; i_sum = 4'd7;
    @(posedge i_clock);
    @(negedge i_clock);
    i_sum_valid = 0;
    check("stale_sum_valid", 32'(dut_out()), 32'd0);

    // roll_count saturation via repeated illegal sums in the come-out phase.
    do_reset();
    for (int k = 0; k < RCMAX + 5; k++) roll(13);
    check("rc_saturate", 32'({o_err, o_roll_count}), 32'({1'b1, 8'hff}));

`ifdef CRAPS_STATS_EN
    do_reset();
    roll(7); roll(11); roll(7); roll(2);
    check("win_count", 32'(o_win_count), 32'd3);
    check("lose_count", 32'(o_lose_count), 32'd1);
`endif

    // Randomized run against the rules model; sum_valid density varies to provoke timeouts.
    do_reset();
    model_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int unsigned p;
      p = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 10 : 40);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 2) == 0) i_roll_btn = ~i_roll_btn;
        i_sum_valid = ($urandom_range(0, 99) < p);
        i_sum = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(2, 12));
        @(posedge i_clock);
        model_edge(i_roll_btn, i_sum_valid, int'(i_sum));
        @(negedge i_clock);
        check($sformatf("rand%0d_%0d", blk, c), 32'(dut_out()), 32'(model_out()));
`ifdef CRAPS_STATS_EN
        check($sformatf("rand_stats%0d_%0d", blk, c), 32'({o_win_count, o_lose_count}),
              32'({8'(m_wins), 8'(m_losses)}));
`endif
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
